// File: rtl/hx711_filter_if.sv
// Bus between the HX711 reader side and the filter: raw word in, filtered result out.
// The tare strobe exists only when HX711_FILTER_TARE_EN is defined.
interface hx711_filter_if;
    logic [23:0] weight;
`ifdef HX711_FILTER_TARE_EN
    logic        tare;
`endif
    logic [23:0] value;
    logic        valid;
    logic        ready;
    logic        stale;

`ifdef HX711_FILTER_TARE_EN
    modport master (output weight, output tare, input value, input valid, input ready, input stale);
    modport slave  (input weight, input tare, output value, output valid, output ready, output stale);
`else
    modport master (output weight, input value, input valid, input ready, input stale);
    modport slave  (input weight, output value, output valid, output ready, output stale);
`endif
endinterface

// File: rtl/hx711_filter.sv
// Moving-average filter for an HX711 load-cell word, with a staleness watchdog.
// Optional tare offset register is built only when HX711_FILTER_TARE_EN is defined.
module hx711_filter #(
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 5000000
) (
    input  logic           clk,
    input  logic           rst,
    hx711_filter_if.slave  bus
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 24 + AVG_LOG2;
    localparam int PW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] IDLE_EDGE = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALE = 2'd2;

    logic [23:0]        s1;
    logic [23:0]        s2;
    logic [23:0]        last_raw;
    logic signed [23:0] win_buf [N];
    logic [PW-1:0]      wr_ptr;
    logic [FW-1:0]      fill_cnt;
    logic signed [SW-1:0] sum;
    logic [CW-1:0]      idle_cnt;
    logic [1:0]         state;
    logic               acc_d1;

    logic               accept;
    logic               win_full;
    logic               stale_rise;
    logic signed [SW-1:0] evicted;
    logic signed [SW-1:0] sum_next;
    logic signed [23:0] average;
    logic signed [23:0] offset_next;
    logic signed [24:0] net;
    logic [23:0]        net_sat;

    // A word counts only once it has been seen identical in both sync stages and differs from the last one taken.
    always_comb begin
        accept     = (s1 == s2) && (s2 != last_raw);
        win_full   = (fill_cnt == FILL_FULL);
        stale_rise = !accept && (idle_cnt == IDLE_EDGE);
        evicted    = win_full ? SW'(win_buf[wr_ptr]) : '0;
        sum_next   = sum + SW'($signed(s2)) - evicted;
        average    = 24'(sum >>> AVG_LOG2);
        net        = $signed({average[23], average}) - $signed({offset_next[23], offset_next});
        net_sat    = (net[24] != net[23]) ? (net[24] ? 24'h800000 : 24'h7FFFFF) : net[23:0];
    end

`ifdef HX711_FILTER_TARE_EN
    logic signed [23:0] offset;

    // Tare latches the average as it stands before any coincident accept lands in the sum.
    always_comb offset_next = (bus.tare && state == S_RUN) ? average : offset;

    always_ff @(posedge clk) begin
        if (rst) offset <= '0;
        else     offset <= offset_next;
    end
`else
    always_comb offset_next = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && accept) win_buf[wr_ptr] <= $signed(s2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            last_raw  <= '0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            sum       <= '0;
            idle_cnt  <= '0;
            state     <= S_FILL;
            acc_d1    <= 1'b0;
            bus.valid <= 1'b0;
            bus.value <= '0;
        end else begin
            s1     <= bus.weight;
            s2     <= s1;
            acc_d1 <= accept;

            bus.valid <= 1'b0;
            if (acc_d1 && state == S_RUN) begin
                bus.valid <= 1'b1;
                bus.value <= net_sat;
            end

            // An accept beats the timeout; a timeout forgets the window but keeps value and offset.
            if (accept) begin
                last_raw <= s2;
                idle_cnt <= '0;
                wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
                sum      <= sum_next;
                if (!win_full) fill_cnt <= fill_cnt + FW'(1);
                state    <= (win_full || fill_cnt == FILL_FULL - FW'(1)) ? S_RUN : S_FILL;
            end else if (stale_rise) begin
                idle_cnt <= IDLE_MAX;
                fill_cnt <= '0;
                sum      <= '0;
                wr_ptr   <= '0;
                state    <= S_STALE;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
        end
    end

    assign bus.ready = (state == S_RUN);
    assign bus.stale = (state == S_STALE);

endmodule

// File: tb/tb_hx711_filter.sv
// Randomised bench for hx711_filter against a queue-based window model.
// Tare scenarios are exercised when HX711_FILTER_TARE_EN is defined.
module tb_hx711_filter;

    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;
    localparam int TIMEOUT  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hx711_filter_if bus ();

    hx711_filter #(.AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the window is simply the list of the last N accepted words.
    logic [23:0] m_s1, m_s2, m_last;
    longint      win[$];
    int          m_idle;
    bit          m_acc_d;
    longint      m_offset;
    logic [23:0] exp_value;
    bit          exp_valid;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at time %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic longint window_avg();
        longint s;
        s = 0;
        foreach (win[i]) s += win[i];
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic longint saturate(input longint x);
        if (x > 8388607)  return 8388607;
        if (x < -8388608) return -8388608;
        return x;
    endfunction

    task automatic model_step();
        bit acc;
        bit tare_now;
        bit ready_now;
        tare_now = 1'b0;
`ifdef HX711_FILTER_TARE_EN
        tare_now = bus.tare;
`endif
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_last = '0;
            win.delete();
            m_idle = 0; m_acc_d = 1'b0; m_offset = 0;
            exp_value = '0; exp_valid = 1'b0;
        end else begin
            ready_now = (win.size() == N);
            acc       = (m_s1 == m_s2) && (m_s2 != m_last);
            if (tare_now && ready_now) m_offset = window_avg();
            exp_valid = m_acc_d && ready_now;
            if (exp_valid) exp_value = 24'(saturate(window_avg() - m_offset));
            if (acc) begin
                win.push_back(longint'($signed(m_s2)));
                if (win.size() > N) void'(win.pop_front());
                m_idle = 0;
                m_last = m_s2;
            end else if (m_idle < TIMEOUT) begin
                m_idle++;
                if (m_idle == TIMEOUT) win.delete();
            end
            m_acc_d = acc;
            m_s2    = m_s1;
            m_s1    = bus.weight;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        checkOutput("valid", {31'b0, bus.valid}, {31'b0, exp_valid});
        checkOutput("ready", {31'b0, bus.ready}, {31'b0, (win.size() == N)});
        checkOutput("stale", {31'b0, bus.stale}, {31'b0, (m_idle == TIMEOUT)});
        checkOutput("value", {8'b0, bus.value}, {8'b0, exp_value});
    end

    task automatic applyStimulus(input logic [23:0] w, input int cycles, input bit do_tare = 1'b0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            bus.weight = w;
`ifdef HX711_FILTER_TARE_EN
            bus.tare = do_tare && (i == 0);
`endif
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.weight = '0;
`ifdef HX711_FILTER_TARE_EN
        bus.tare = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog: still running at time %0t, expected to finish sooner", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] w;
        logic [23:0] nw;
        int          r;
        int          hold;

        bus.weight = '0;
`ifdef HX711_FILTER_TARE_EN
        bus.tare = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_value", {8'b0, bus.value}, 32'd0);
        checkOutput("reset_ready", {31'b0, bus.ready}, 32'd0);
        rst = 1'b0;

        // Window of four fills, then one more sample evicts the oldest.
        applyStimulus(24'd100, 10);
        applyStimulus(24'd200, 10);
        applyStimulus(24'd300, 10);
        checkOutput("fill_not_ready", {31'b0, bus.ready}, 32'd0);
        applyStimulus(24'd400, 10);
        checkOutput("avg_250", {8'b0, bus.value}, 32'd250);
        checkOutput("ready_full", {31'b0, bus.ready}, 32'd1);
        applyStimulus(24'd500, 10);
        checkOutput("avg_350", {8'b0, bus.value}, 32'd350);

        // Constant input runs out the watchdog; a new word starts refilling.
        applyStimulus(24'd500, TIMEOUT + 5);
        checkOutput("stale_high", {31'b0, bus.stale}, 32'd1);
        checkOutput("stale_ready", {31'b0, bus.ready}, 32'd0);
        checkOutput("stale_hold", {8'b0, bus.value}, 32'd350);
        applyStimulus(24'd600, 10);
        checkOutput("stale_clear", {31'b0, bus.stale}, 32'd0);
        checkOutput("refill_ready", {31'b0, bus.ready}, 32'd0);

`ifdef HX711_FILTER_TARE_EN
        applyReset();
        applyStimulus(24'd100, 10);
        applyStimulus(24'd200, 10);
        applyStimulus(24'd300, 10);
        applyStimulus(24'd400, 10);
        applyStimulus(24'd400, 6, 1'b1);
        applyStimulus(24'd249, 10);
        applyStimulus(24'd251, 10);
        applyStimulus(24'd249, 10);
        applyStimulus(24'd251, 10);
        checkOutput("tare_zero", {8'b0, bus.value}, 32'd0);

        applyReset();
        applyStimulus(24'd1, 10);
        applyStimulus(24'd2, 10);
        applyStimulus(24'd1, 10);
        applyStimulus(24'd0, 10);
        applyStimulus(24'd0, 6, 1'b1);
        applyStimulus(24'h800000, 10);
        applyStimulus(24'h800001, 10);
        applyStimulus(24'h800000, 10);
        applyStimulus(24'h800001, 10);
        checkOutput("sat_neg", {8'b0, bus.value}, {8'b0, 24'h800000});

        applyReset();
        applyStimulus(24'hFFFFFE, 10);
        applyStimulus(24'hFFFFFF, 10);
        applyStimulus(24'hFFFFFD, 10);
        applyStimulus(24'hFFFFFE, 10);
        applyStimulus(24'hFFFFFE, 6, 1'b1);
        applyStimulus(24'h7FFFFF, 10);
        applyStimulus(24'h7FFFFE, 10);
        applyStimulus(24'h7FFFFF, 10);
        applyStimulus(24'h7FFFFE, 10);
        checkOutput("sat_pos", {8'b0, bus.value}, {8'b0, 24'h7FFFFF});
`endif

        // Reset part-way through a window discards the partial samples.
        applyReset();
        applyStimulus(24'd10, 10);
        applyStimulus(24'd20, 10);
        applyReset();
        checkOutput("midreset_value", {8'b0, bus.value}, 32'd0);
        checkOutput("midreset_ready", {31'b0, bus.ready}, 32'd0);
        applyStimulus(24'd30, 10);
        applyStimulus(24'd40, 10);
        applyStimulus(24'd50, 10);
        checkOutput("three_not_ready", {31'b0, bus.ready}, 32'd0);
        applyStimulus(24'd60, 10);
        checkOutput("avg_45", {8'b0, bus.value}, 32'd45);

        // A word that never settles for two cycles is never taken.
        for (int i = 0; i < TIMEOUT + 10; i++) applyStimulus(24'd1000 + 24'(i), 1);
        checkOutput("glitch_stale", {31'b0, bus.stale}, 32'd1);

        w = 24'd7;
        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                applyReset();
            end else begin
                if (r < 13)      nw = w;
                else if (r < 40) nw = 24'($urandom_range(0, 2000)) - 24'd1000;
                else             nw = 24'($urandom);
                w    = nw;
                hold = (r >= 96) ? TIMEOUT + 5 : int'($urandom_range(1, 4));
                applyStimulus(w, hold, ($urandom_range(0, 99) < 15));
            end
        end

        repeat (5) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/hx711_filter.md
HX711_FILTER -- requirements
Module: hx711_filter

Interface
REQ-001 Parameter AVG_LOG2, default 3, SHALL set the moving-average window to 2^AVG_LOG2 samples (legal range 0..6).
REQ-002 Parameter TIMEOUT, default 5000000, SHALL set the clk cycles without an accepted sample before stale asserts (legal range >= 1).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 weight  input  24  raw load-cell word from the upstream HX711 reader; asynchronous to clk (derived-clock domain); two's complement.
REQ-006 tare  input  1  single-cycle pulse; captures current average as zero offset (present only with HX711_FILTER_TARE_EN).
REQ-007 value  output  24  net filtered weight, signed, saturated.
REQ-008 valid  output  1  one-cycle pulse when value updates.
REQ-009 ready  output  1  high once the averaging window is full.
REQ-010 stale  output  1  high when no new sample has been accepted for TIMEOUT cycles.

Function
REQ-011 weight SHALL pass through two clk registers (s1, s2) before any use.
REQ-012 A sample SHALL be accepted in a cycle where s2 == s1 (stable) and s2 != last accepted raw word; last raw SHALL update in the same cycle.
REQ-013 Identical consecutive raw words SHALL NOT be accepted; only stale reports their absence.
REQ-014 Accepted samples SHALL enter a 2^AVG_LOG2-entry circular buffer; the write pointer SHALL wrap from 2^AVG_LOG2-1 to 0.
REQ-015 A running sum of width 24+AVG_LOG2 bits, signed, SHALL update as sum + new - evicted, with evicted treated as 0 until the buffer is full.
REQ-016 Fill count SHALL saturate at 2^AVG_LOG2; ready SHALL assert the cycle the sum includes the 2^AVG_LOG2-th sample and remain high until reset or stale.
REQ-017 Average SHALL be sum arithmetically shifted right by AVG_LOG2; value SHALL equal average minus tare offset, saturated to [-8388608, 8388607].
REQ-018 valid SHALL pulse exactly 2 clk cycles after the accept cycle, only while ready is high; value SHALL hold between pulses.
REQ-019 Idle counter SHALL clear on accept, increment otherwise, and saturate at TIMEOUT; stale SHALL be high while counter == TIMEOUT.
REQ-020 On the cycle stale rises, fill count, sum and ready SHALL clear; buffer contents SHALL be treated as empty; offset and value SHALL be retained.
REQ-021 An accept in the same cycle stale would rise SHALL win: counter clears, no flush.
REQ-022 Control sequencing SHALL be a three-state machine: FILL (ready=0), RUN (ready=1), STALE (stale=1); FILL->RUN on window full, any->STALE on timeout, STALE->FILL on next accept.

Reset
REQ-023 While rst is high: value=0, valid=0, ready=0, stale=0, sum=0, fill count=0, pointer=0, idle counter=0, last raw=0, s1=s2=0, offset=0, state=FILL.
REQ-024 rst asserted mid-window SHALL discard all partial samples; first accept after release starts a fresh window.

Configuration
REQ-025 Macro HX711_FILTER_TARE_EN: defined -> tare port and 24-bit offset register exist; tare while ready=1 loads offset with the current average (pre-update value if an accept coincides) and the next valid reports value relative to it; tare while ready=0 SHALL be ignored.
REQ-026 HX711_FILTER_TARE_EN undefined -> no tare port, offset constant 0, value = saturated average.

Verification
REQ-027 AVG_LOG2=2, feed 100,200,300,400 (each held 10 cycles) -> ready rises at 4th sample, valid 2 cycles after accept, value=250.
REQ-028 Then feed 500 -> value=350; pointer wraps, 100 evicted.
REQ-029 Hold weight constant for TIMEOUT=50 cycles -> stale=1 at cycle 50, ready=0; next distinct word -> stale=0, state FILL.
REQ-030 TARE_EN, window full at average 250, pulse tare, feed 250-average data -> value=0; AVG_LOG2=2 with -8388608 samples and offset 1 -> value saturates at -8388608.
REQ-031 rst asserted after 2 of 4 samples -> all outputs 0; 4 new samples required before first valid.
REQ-032 weight glitching every cycle (never stable 2 cycles) -> no accept, no valid, stale after TIMEOUT.
